param_readout: RTL and testbench

PARAM_READOUT -- requirements
Module: param_readout

---
 rtl/param_readout.sv | 102 ++++++++++
 tb/tb_param_readout.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_readout.sv
// APB read-only window onto a bank of parameter words, with programmable
// wait states, error response and a saturating successful-read counter.
module param_readout #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned NUM_SLAVE   = 8,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             psel,
   input  logic                             penable,
   input  logic                             pwrite,
   input  logic [ADDR_W-1:0]                paddr,
   input  logic [NUM_SLAVE-1:0][WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]                 prdata,
   output logic                             pready,
   output logic                             pslverr,
   output logic [15:0]                      rd_count
);

   localparam int unsigned IDX_W     = ADDR_W - 2;
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t             state_q, state_d;
   logic [3:0]         wait_cnt_q, wait_cnt_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   snap_q, snap_d;
   logic [15:0]        rd_count_q;
   logic [IDX_W-1:0]   idx;
   logic [WIDTH-1:0]   word;
   logic               idx_ok;
   logic               setup;
   logic               wait_done;

   assign idx       = paddr[ADDR_W-1:2];
   assign idx_ok    = (32'(idx) < NUM_SLAVE);
   assign setup     = psel && !penable;
   assign wait_done = (wait_cnt_q == WAIT_LAST);

   // Word select as a mux so an out-of-range index naturally yields zero.
   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < NUM_SLAVE; i++) begin
         if (32'(idx) == i) word = data_in[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      snap_d     = snap_q;
      pready     = 1'b0;
      case (state_q)
         IDLE: begin
            if (setup) begin
               state_d    = ACCESS;
               err_d      = pwrite || (paddr[1:0] != 2'b00) || !idx_ok;
               snap_d     = word;
               wait_cnt_d = '0;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (wait_done) begin
                  pready  = 1'b1;
                  state_d = IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
         snap_q     <= '0;
         rd_count_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         snap_q     <= snap_d;
         if (pready && !err_q && (rd_count_q != '1)) rd_count_q <= rd_count_q + 16'd1;
      end
   end

   assign prdata   = (pready && !err_q) ? snap_q : '0;
   assign pslverr  = pready && err_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_param_readout.sv
// Scoreboard bench for param_readout: four instances, one per wait-state
// setting, share the bus and are selected individually through psel.
module tb_param_readout;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned NUM_SLAVE = 8;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned NDUT      = 4;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   logic                            clk = 1'b0;
   logic                            rst_n;
   logic [NDUT-1:0]                 psel;
   logic                            penable;
   logic                            pwrite;
   logic [ADDR_W-1:0]               paddr;
   logic [NUM_SLAVE-1:0][WIDTH-1:0] data_in;
   logic [WIDTH-1:0]                prdata   [NDUT];
   logic                            pready   [NDUT];
   logic                            pslverr  [NDUT];
   logic [15:0]                     rd_count [NDUT];

   exp_t        sb[$];
   logic [15:0] exp_cnt [NDUT];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      param_readout #(
         .WIDTH       (WIDTH),
         .NUM_SLAVE   (NUM_SLAVE),
         .ADDR_W      (ADDR_W),
         .WAIT_CYCLES (g)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .psel     (psel[g]),
         .penable  (penable),
         .pwrite   (pwrite),
         .paddr    (paddr),
         .data_in  (data_in),
         .prdata   (prdata[g]),
         .pready   (pready[g]),
         .pslverr  (pslverr[g]),
         .rd_count (rd_count[g])
      );
   end

   // One APB transfer on instance w. Returns on the pready cycle with the bus
   // still active, so a following call forms a back-to-back transfer.
   task automatic xfer(input int unsigned w, input logic [7:0] addr, input logic wr,
                       input int unsigned abort_at, input int unsigned mod_at,
                       input logic [WIDTH-1:0] mod_val,
                       output logic done, output int unsigned lat,
                       output logic [WIDTH-1:0] d, output logic e, output logic leak);
      logic [5:0] idx;
      exp_t       x;
      done = 1'b0; lat = 0; d = '0; e = 1'b0; leak = 1'b0;
      @(posedge clk); #1;
      psel = '0; psel[w] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      idx    = addr[7:2];
      x.err  = wr || (addr[1:0] != 2'b00) || (idx >= 6'(NUM_SLAVE));
      x.data = x.err ? '0 : data_in[idx[2:0]];
      if (abort_at == 0) sb.push_back(x);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++)
         if (pready[i] || (prdata[i] != '0) || pslverr[i]) leak = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int unsigned n = 1; n <= 20; n++) begin
         if (n == abort_at) begin psel = '0; penable = 1'b0; end
         @(negedge clk);
         for (int unsigned i = 0; i < NDUT; i++)
            if ((i != w) && (pready[i] || (prdata[i] != '0) || pslverr[i])) leak = 1'b1;
         if (pready[w]) begin
            done = 1'b1; lat = n; d = prdata[w]; e = pslverr[w];
            break;
         end
         if ((prdata[w] != '0) || pslverr[w]) leak = 1'b1;
         if ((mod_at == n) && (idx < 6'(NUM_SLAVE))) data_in[idx[2:0]] = mod_val;
         if ((abort_at != 0) && (n == abort_at + 1)) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel = '0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      for (int i = 0; i < NUM_SLAVE; i++) data_in[i] = {16'hA5A5, 16'(i)};
      for (int i = 0; i < NDUT; i++) exp_cnt[i] = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if ((prdata[i] !== '0) || (pready[i] !== 1'b0) || (pslverr[i] !== 1'b0) || (rd_count[i] !== 16'h0)) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: got prdata=%h pready=%b pslverr=%b rd_count=%h, expected all zero",
                     i, prdata[i], pready[i], pslverr[i], rd_count[i]);
         end
      end
   endtask

   // Setup phase presented on the first edge after reset release, WAIT_CYCLES=1.
   task automatic test_basic();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      fork
         xfer(1, 8'h0C, 1'b0, 0, 0, '0, done, lat, d, e, leak);
         begin @(posedge clk); #2; rst_n = 1'b1; end
      join
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
      checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      x = sb.pop_front();
      checks++; if (d !== x.data) begin errors++; $display("FAIL basic_prdata: got %h expected %h", d, x.data); end
      checks++; if (e !== x.err) begin errors++; $display("FAIL basic_pslverr: got %b expected %b", e, x.err); end
      checks++; if (leak !== 1'b0) begin errors++; $display("FAIL basic_leak: got %b expected 0", leak); end
      exp_cnt[1] = exp_cnt[1] + 16'd1;
      bus_idle();
      checks++; if (rd_count[1] !== exp_cnt[1]) begin errors++; $display("FAIL basic_count: got %h expected %h", rd_count[1], exp_cnt[1]); end
   endtask

   task automatic test_back_to_back();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      logic [7:0] addrs [2];
      addrs[0] = 8'h00; addrs[1] = 8'h1C;
      for (int k = 0; k < 2; k++) begin
         xfer(0, addrs[k], 1'b0, 0, 0, '0, done, lat, d, e, leak);
         checks++; if ((done !== 1'b1) || (lat != 1)) begin errors++; $display("FAIL b2b_latency[%0d]: got done=%b lat=%0d expected done=1 lat=1", k, done, lat); end
         x = sb.pop_front();
         checks++; if (d !== x.data) begin errors++; $display("FAIL b2b_prdata[%0d]: got %h expected %h", k, d, x.data); end
         checks++; if ((e !== 1'b0) || (leak !== 1'b0)) begin errors++; $display("FAIL b2b_err_leak[%0d]: got pslverr=%b leak=%b expected 0 0", k, e, leak); end
         if (!x.err) exp_cnt[0] = exp_cnt[0] + 16'd1;
      end
      bus_idle();
      checks++; if (rd_count[0] !== exp_cnt[0]) begin errors++; $display("FAIL b2b_count: got %h expected %h", rd_count[0], exp_cnt[0]); end
   endtask

   task automatic test_errors();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      logic [7:0] addrs [3];
      logic       wrs   [3];
      addrs[0] = 8'h20; wrs[0] = 1'b0;
      addrs[1] = 8'h02; wrs[1] = 1'b0;
      addrs[2] = 8'h04; wrs[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         xfer(1, addrs[k], wrs[k], 0, 0, '0, done, lat, d, e, leak);
         checks++; if ((done !== 1'b1) || (lat != 2)) begin errors++; $display("FAIL err_latency[%0d]: got done=%b lat=%0d expected done=1 lat=2", k, done, lat); end
         x = sb.pop_front();
         checks++; if ((d !== x.data) || (e !== x.err)) begin errors++; $display("FAIL err_resp[%0d]: got prdata=%h pslverr=%b expected %h %b", k, d, e, x.data, x.err); end
         checks++; if (leak !== 1'b0) begin errors++; $display("FAIL err_leak[%0d]: got %b expected 0", k, leak); end
      end
      bus_idle();
      checks++; if (rd_count[1] !== exp_cnt[1]) begin errors++; $display("FAIL err_count: got %h expected %h", rd_count[1], exp_cnt[1]); end
   endtask

   task automatic test_snapshot();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      data_in[1] = 32'h1111_1111;
      xfer(3, 8'h04, 1'b0, 0, 1, 32'h2222_2222, done, lat, d, e, leak);
      checks++; if ((done !== 1'b1) || (lat != 4)) begin errors++; $display("FAIL snap_latency: got done=%b lat=%0d expected done=1 lat=4", done, lat); end
      x = sb.pop_front();
      checks++; if (d !== x.data) begin errors++; $display("FAIL snap_prdata: got %h expected %h", d, x.data); end
      checks++; if ((e !== 1'b0) || (leak !== 1'b0)) begin errors++; $display("FAIL snap_err_leak: got pslverr=%b leak=%b expected 0 0", e, leak); end
      exp_cnt[3] = exp_cnt[3] + 16'd1;
      bus_idle();
      checks++; if (rd_count[3] !== exp_cnt[3]) begin errors++; $display("FAIL snap_count: got %h expected %h", rd_count[3], exp_cnt[3]); end
   endtask

   task automatic test_abort();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      xfer(2, 8'h08, 1'b0, 1, 0, '0, done, lat, d, e, leak);
      checks++; if ((done !== 1'b0) || (leak !== 1'b0)) begin errors++; $display("FAIL abort_no_ready: got done=%b leak=%b expected 0 0", done, leak); end
      bus_idle();
      checks++; if (rd_count[2] !== exp_cnt[2]) begin errors++; $display("FAIL abort_count: got %h expected %h", rd_count[2], exp_cnt[2]); end
      xfer(2, 8'h08, 1'b0, 0, 0, '0, done, lat, d, e, leak);
      checks++; if ((done !== 1'b1) || (lat != 3)) begin errors++; $display("FAIL abort_next_latency: got done=%b lat=%0d expected done=1 lat=3", done, lat); end
      x = sb.pop_front();
      checks++; if ((d !== x.data) || (e !== 1'b0)) begin errors++; $display("FAIL abort_next_resp: got prdata=%h pslverr=%b expected %h 0", d, e, x.data); end
      exp_cnt[2] = exp_cnt[2] + 16'd1;
      bus_idle();
      checks++; if (rd_count[2] !== exp_cnt[2]) begin errors++; $display("FAIL abort_next_count: got %h expected %h", rd_count[2], exp_cnt[2]); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      psel = '0; psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
      @(posedge clk); #1;
      penable = 1'b1;
      #1;
      checks++; if (pready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ready: got %b expected 1", pready[0]); end
      rst_n = 1'b0;
      #1;
      checks++; if ((pready[0] !== 1'b0) || (prdata[0] !== '0) || (pslverr[0] !== 1'b0)) begin
         errors++; $display("FAIL rstmid_drop: got pready=%b prdata=%h pslverr=%b expected 0 0 0", pready[0], prdata[0], pslverr[0]);
      end
      for (int i = 0; i < NDUT; i++) exp_cnt[i] = '0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if ((prdata[i] !== '0) || (pready[i] !== 1'b0) || (pslverr[i] !== 1'b0) || (rd_count[i] !== exp_cnt[i])) begin
            errors++;
            $display("FAIL rstmid_clear dut%0d: got prdata=%h pready=%b pslverr=%b rd_count=%h expected all zero",
                     i, prdata[i], pready[i], pslverr[i], rd_count[i]);
         end
      end
      @(posedge clk); #1;
      psel = '0; penable = 1'b0; rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Counter preloaded near the top, then driven through the saturation point.
   task automatic test_saturation();
      logic done, e, leak; int unsigned lat; logic [WIDTH-1:0] d; exp_t x;
      @(negedge clk);
      g_dut[0].u_dut.rd_count_q = 16'hFFFC;
      exp_cnt[0] = 16'hFFFC;
      #1;
      checks++; if (rd_count[0] !== exp_cnt[0]) begin errors++; $display("FAIL sat_preload: got %h expected %h", rd_count[0], exp_cnt[0]); end
      for (int k = 0; k < 4; k++) begin
         xfer(0, 8'(k * 4), 1'b0, 0, 0, '0, done, lat, d, e, leak);
         x = sb.pop_front();
         checks++; if ((done !== 1'b1) || (d !== x.data) || (e !== 1'b0)) begin
            errors++; $display("FAIL sat_read[%0d]: got done=%b prdata=%h pslverr=%b expected 1 %h 0", k, done, d, e, x.data);
         end
         if (exp_cnt[0] != 16'hFFFF) exp_cnt[0] = exp_cnt[0] + 16'd1;
         if (k == 2) begin
            bus_idle();
            checks++; if (rd_count[0] !== exp_cnt[0]) begin errors++; $display("FAIL sat_reach: got %h expected %h", rd_count[0], exp_cnt[0]); end
         end
      end
      bus_idle();
      checks++; if (rd_count[0] !== exp_cnt[0]) begin errors++; $display("FAIL sat_hold: got %h expected %h", rd_count[0], exp_cnt[0]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_errors();
      test_snapshot();
      test_abort();
      test_reset_mid();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
